// File: rtl/reg_bank_arbiter_if.sv
// Request, response and bank bus bundle for reg_bank_arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the bank.
interface reg_bank_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
);
  logic             req0_valid;
  logic             req0_we;
  logic [AW-1:0]    req0_addr;
  logic [WIDTH-1:0] req0_wdata;
  logic             req0_ready;

  logic             req1_valid;
  logic             req1_we;
  logic [AW-1:0]    req1_addr;
  logic [WIDTH-1:0] req1_wdata;
  logic             req1_ready;

  logic             rsp0_valid;
  logic             rsp1_valid;
  logic [WIDTH-1:0] rsp_rdata;

  logic             bank_load;
  logic [AW-1:0]    bank_addr;
  logic [WIDTH-1:0] bank_din;
  logic [WIDTH-1:0] bank_dout;

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_rdata,
    input  bank_load, bank_addr, bank_din,
    output bank_dout
  );

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_rdata,
    output bank_load, bank_addr, bank_din,
    input  bank_dout
  );
endinterface

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter sharing one register bank between two requesters.
// Reads stall while a recent write to the same address is still propagating.
module reg_bank_arbiter #(
  parameter int WIDTH  = 16,
  parameter int AW     = 3,
  parameter int WR_LAT = 2
) (
  input logic               clk,
  input logic               rst,
  reg_bank_arbiter_if.slave bus
);
  // With WR_LAT = 1 a single dummy entry exists but never holds a valid write.
  localparam int HL = (WR_LAT > 1) ? WR_LAT - 1 : 1;
  localparam logic HIST_EN = (WR_LAT > 1);

  logic [HL-1:0]         hv_q, hv_d;
  logic [HL-1:0][AW-1:0] ha_q, ha_d;
  logic                  last_q, last_d;
  logic                  rsp0_q, rsp0_d;
  logic                  rsp1_q, rsp1_d;
  logic [WIDTH-1:0]      rdata_q, rdata_d;

  logic             blk0, blk1;
  logic             el0, el1;
  logic             g0, g1;
  logic             g_any, g_we;
  logic [AW-1:0]    g_addr;
  logic [WIDTH-1:0] g_wdata;

  // Read-after-write hazard: compare each read address to the write history.
  always_comb begin
    blk0 = 1'b0;
    blk1 = 1'b0;
    for (int i = 0; i < HL; i++) begin
      if (hv_q[i] && ha_q[i] == bus.req0_addr)
        blk0 = 1'b1;
      if (hv_q[i] && ha_q[i] == bus.req1_addr)
        blk1 = 1'b1;
    end
  end

  // Eligibility and round-robin grant; last_q = 1 means req1 won last.
  always_comb begin
    el0 = bus.req0_valid && (bus.req0_we || !blk0);
    el1 = bus.req1_valid && (bus.req1_we || !blk1);
    g0  = !rst && el0 && (!el1 || last_q);
    g1  = !rst && el1 && (!el0 || !last_q);
  end

  // Mux the granted request onto the bank and drive the handshake outputs.
  always_comb begin
    g_any   = g0 || g1;
    g_we    = 1'b0;
    g_addr  = '0;
    g_wdata = '0;
    unique case (1'b1)
      g0: begin
        g_we    = bus.req0_we;
        g_addr  = bus.req0_addr;
        g_wdata = bus.req0_wdata;
      end
      g1: begin
        g_we    = bus.req1_we;
        g_addr  = bus.req1_addr;
        g_wdata = bus.req1_wdata;
      end
      default: ;
    endcase
    bus.req0_ready = g0;
    bus.req1_ready = g1;
    bus.bank_load  = g_any && g_we;
    bus.bank_addr  = g_addr;
    bus.bank_din   = (g_any && g_we) ? g_wdata : '0;
  end

  // Next state: fairness pointer, read response capture, write history shift.
  always_comb begin
    last_d  = last_q;
    rsp0_d  = g0 && !bus.req0_we;
    rsp1_d  = g1 && !bus.req1_we;
    rdata_d = rdata_q;
    if (g0)
      last_d = 1'b0;
    if (g1)
      last_d = 1'b1;
    if (rsp0_d || rsp1_d)
      rdata_d = bus.bank_dout;
    hv_d    = '0;
    ha_d    = '0;
    hv_d[0] = HIST_EN && g_any && g_we;
    ha_d[0] = g_addr;
    for (int i = 1; i < HL; i++) begin
      hv_d[i] = hv_q[i-1];
      ha_d[i] = ha_q[i-1];
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      hv_q    <= '0;
      ha_q    <= '0;
      last_q  <= 1'b1;
      rsp0_q  <= 1'b0;
      rsp1_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      hv_q    <= hv_d;
      ha_q    <= ha_d;
      last_q  <= last_d;
      rsp0_q  <= rsp0_d;
      rsp1_q  <= rsp1_d;
      rdata_q <= rdata_d;
    end
  end

  // Registered response outputs.
  always_comb begin
    bus.rsp0_valid = rsp0_q;
    bus.rsp1_valid = rsp1_q;
    bus.rsp_rdata  = rdata_q;
  end
endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter with a WR_LAT-delayed bank model.
// Inputs change 1ns after posedge; outputs are checked on the negedge.
module tb_reg_bank_arbiter;
  localparam int WIDTH  = 16;
  localparam int AW     = 3;
  localparam int WR_LAT = 2;
  localparam int PL     = WR_LAT - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bank_clr = 1'b1;
  int   tests = 0;
  int   fails = 0;

  reg_bank_arbiter_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  reg_bank_arbiter #(
    .WIDTH (WIDTH),
    .AW    (AW),
    .WR_LAT(WR_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] mem  [2**AW];
  logic             pl_v [PL];
  logic [AW-1:0]    pl_a [PL];
  logic [WIDTH-1:0] pl_d [PL];

  assign bus.bank_dout = mem[bus.bank_addr];

  always @(posedge clk) begin
    if (bank_clr) begin
      for (int i = 0; i < 2**AW; i++)
        mem[i] <= WIDTH'(32'h1000 + i);
      for (int j = 0; j < PL; j++)
        pl_v[j] <= 1'b0;
    end else begin
      pl_v[0] <= bus.bank_load;
      pl_a[0] <= bus.bank_addr;
      pl_d[0] <= bus.bank_din;
      for (int j = 1; j < PL; j++) begin
        pl_v[j] <= pl_v[j-1];
        pl_a[j] <= pl_a[j-1];
        pl_d[j] <= pl_d[j-1];
      end
      if (pl_v[PL-1])
        mem[pl_a[PL-1]] <= pl_d[PL-1];
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic drive0(input logic v, input logic we,
                        input int a, input int d);
    bus.req0_valid = v;
    bus.req0_we    = we;
    bus.req0_addr  = AW'(a);
    bus.req0_wdata = WIDTH'(d);
  endtask

  task automatic drive1(input logic v, input logic we,
                        input int a, input int d);
    bus.req1_valid = v;
    bus.req1_we    = we;
    bus.req1_addr  = AW'(a);
    bus.req1_wdata = WIDTH'(d);
  endtask

  task automatic idle();
    drive0(0, 0, 0, 0);
    drive1(0, 0, 0, 0);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bank_clr = 1'b1;
    drive0(1, 1, 3, 'hFFFF);
    drive1(1, 0, 4, 0);
    settle();
    tests++;
    if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_ready: got %b%b want 00",
               bus.req0_ready, bus.req1_ready);
    end
    tests++;
    if (bus.bank_load !== 1'b0) begin
      fails++;
      $display("FAIL reset_load: got %b want 0", bus.bank_load);
    end
    tests++;
    if (bus.bank_addr !== '0 || bus.bank_din !== '0) begin
      fails++;
      $display("FAIL reset_bus: got addr %0d din %h want 0 0",
               bus.bank_addr, bus.bank_din);
    end
    nxt();
    settle();
    tests++;
    if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_rsp: got %b%b want 00",
               bus.rsp0_valid, bus.rsp1_valid);
    end
    tests++;
    if (bus.rsp_rdata !== '0) begin
      fails++;
      $display("FAIL reset_rdata: got %h want 0", bus.rsp_rdata);
    end
    idle();
    nxt();
    rst = 1'b0;
    bank_clr = 1'b0;
  endtask

  task automatic test_write_read();
    drive0(1, 1, 3, 'hBEEF);
    settle();
    tests++;
    if (bus.req0_ready !== 1'b1 || bus.bank_load !== 1'b1) begin
      fails++;
      $display("FAIL wr_grant: got rdy %b load %b want 1 1",
               bus.req0_ready, bus.bank_load);
    end
    tests++;
    if (bus.bank_addr !== 3'd3 || bus.bank_din !== 16'hBEEF) begin
      fails++;
      $display("FAIL wr_bus: got addr %0d din %h want 3 beef",
               bus.bank_addr, bus.bank_din);
    end
    nxt();
    drive0(1, 0, 3, 0);
    settle();
    tests++;
    if (bus.req0_ready !== 1'b0 || bus.bank_load !== 1'b0) begin
      fails++;
      $display("FAIL raw_block: got rdy %b load %b want 0 0",
               bus.req0_ready, bus.bank_load);
    end
    tests++;
    if (bus.rsp0_valid !== 1'b0) begin
      fails++;
      $display("FAIL wr_no_rsp: got %b want 0", bus.rsp0_valid);
    end
    nxt();
    settle();
    tests++;
    if (bus.req0_ready !== 1'b1 || bus.bank_addr !== 3'd3
        || bus.bank_din !== '0) begin
      fails++;
      $display("FAIL rd_grant: got rdy %b addr %0d din %h want 1 3 0",
               bus.req0_ready, bus.bank_addr, bus.bank_din);
    end
    nxt();
    idle();
    settle();
    tests++;
    if (bus.rsp0_valid !== 1'b1 || bus.rsp1_valid !== 1'b0
        || bus.rsp_rdata !== 16'hBEEF) begin
      fails++;
      $display("FAIL rd_rsp: got v%b%b %h want v10 beef",
               bus.rsp0_valid, bus.rsp1_valid, bus.rsp_rdata);
    end
    nxt();
  endtask

  task automatic test_round_robin();
    logic       e0, e1, p0;
    logic [15:0] pd;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive0(1, 0, 0, 0);
      drive1(1, 0, 7, 0);
      settle();
      e0 = (k % 2 == 0);
      e1 = !e0;
      tests++;
      if (bus.req0_ready !== e0 || bus.req1_ready !== e1) begin
        fails++;
        $display("FAIL rr_grant%0d: got %b%b want %b%b", k,
                 bus.req0_ready, bus.req1_ready, e0, e1);
      end
      if (k > 0) begin
        p0 = !e0;
        pd = p0 ? 16'h1000 : 16'h1007;
        tests++;
        if (bus.rsp0_valid !== p0 || bus.rsp1_valid !== !p0
            || bus.rsp_rdata !== pd) begin
          fails++;
          $display("FAIL rr_rsp%0d: got v%b%b %h want v%b%b %h", k,
                   bus.rsp0_valid, bus.rsp1_valid, bus.rsp_rdata,
                   p0, !p0, pd);
        end
      end
      nxt();
    end
    idle();
    settle();
    tests++;
    if (bus.rsp1_valid !== 1'b1 || bus.rsp_rdata !== 16'h1007) begin
      fails++;
      $display("FAIL rr_last: got v%b %h want v1 1007",
               bus.rsp1_valid, bus.rsp_rdata);
    end
    nxt();
  endtask

  task automatic test_cross_hazard();
    do_reset();
    drive0(1, 0, 0, 0);
    settle();
    tests++;
    if (bus.req0_ready !== 1'b1) begin
      fails++;
      $display("FAIL xh_setup: got %b want 1", bus.req0_ready);
    end
    nxt();
    drive0(1, 0, 5, 0);
    drive1(1, 1, 5, 'h1234);
    settle();
    tests++;
    if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0
        || bus.bank_load !== 1'b1 || bus.bank_din !== 16'h1234) begin
      fails++;
      $display("FAIL xh_write: got rdy %b%b load %b din %h want 01 1 1234",
               bus.req0_ready, bus.req1_ready, bus.bank_load, bus.bank_din);
    end
    tests++;
    if (bus.rsp0_valid !== 1'b1 || bus.rsp_rdata !== 16'h1000) begin
      fails++;
      $display("FAIL xh_prev_rsp: got v%b %h want v1 1000",
               bus.rsp0_valid, bus.rsp_rdata);
    end
    nxt();
    drive1(0, 0, 0, 0);
    settle();
    tests++;
    if (bus.req0_ready !== 1'b0) begin
      fails++;
      $display("FAIL xh_block: got %b want 0", bus.req0_ready);
    end
    nxt();
    settle();
    tests++;
    if (bus.req0_ready !== 1'b1 || bus.bank_addr !== 3'd5) begin
      fails++;
      $display("FAIL xh_grant: got rdy %b addr %0d want 1 5",
               bus.req0_ready, bus.bank_addr);
    end
    nxt();
    idle();
    settle();
    tests++;
    if (bus.rsp0_valid !== 1'b1 || bus.rsp_rdata !== 16'h1234) begin
      fails++;
      $display("FAIL xh_rsp: got v%b %h want v1 1234",
               bus.rsp0_valid, bus.rsp_rdata);
    end
    nxt();
  endtask

  task automatic test_bypass();
    drive0(1, 1, 2, 'h2222);
    settle();
    tests++;
    if (bus.req0_ready !== 1'b1) begin
      fails++;
      $display("FAIL by_write: got %b want 1", bus.req0_ready);
    end
    nxt();
    drive0(1, 0, 2, 0);
    drive1(1, 0, 6, 0);
    settle();
    tests++;
    if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b1
        || bus.bank_addr !== 3'd6) begin
      fails++;
      $display("FAIL by_pass: got rdy %b%b addr %0d want 01 6",
               bus.req0_ready, bus.req1_ready, bus.bank_addr);
    end
    nxt();
    drive1(0, 0, 0, 0);
    settle();
    tests++;
    if (bus.rsp1_valid !== 1'b1 || bus.rsp_rdata !== 16'h1006) begin
      fails++;
      $display("FAIL by_rsp1: got v%b %h want v1 1006",
               bus.rsp1_valid, bus.rsp_rdata);
    end
    tests++;
    if (bus.req0_ready !== 1'b1) begin
      fails++;
      $display("FAIL by_late: got %b want 1", bus.req0_ready);
    end
    nxt();
    idle();
    settle();
    tests++;
    if (bus.rsp0_valid !== 1'b1 || bus.rsp_rdata !== 16'h2222) begin
      fails++;
      $display("FAIL by_rsp0: got v%b %h want v1 2222",
               bus.rsp0_valid, bus.rsp_rdata);
    end
    nxt();
  endtask

  task automatic test_write_write();
    do_reset();
    drive0(1, 1, 1, 'hAAAA);
    drive1(1, 1, 1, 'h5555);
    settle();
    tests++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0
        || bus.bank_din !== 16'hAAAA) begin
      fails++;
      $display("FAIL ww_first: got rdy %b%b din %h want 10 aaaa",
               bus.req0_ready, bus.req1_ready, bus.bank_din);
    end
    nxt();
    drive0(0, 0, 0, 0);
    settle();
    tests++;
    if (bus.req1_ready !== 1'b1 || bus.bank_din !== 16'h5555
        || bus.bank_addr !== 3'd1) begin
      fails++;
      $display("FAIL ww_second: got rdy %b din %h addr %0d want 1 5555 1",
               bus.req1_ready, bus.bank_din, bus.bank_addr);
    end
    nxt();
    drive1(0, 0, 0, 0);
    drive0(1, 0, 1, 0);
    settle();
    tests++;
    if (bus.req0_ready !== 1'b0) begin
      fails++;
      $display("FAIL ww_block: got %b want 0", bus.req0_ready);
    end
    nxt();
    settle();
    tests++;
    if (bus.req0_ready !== 1'b1) begin
      fails++;
      $display("FAIL ww_rd: got %b want 1", bus.req0_ready);
    end
    nxt();
    idle();
    settle();
    tests++;
    if (bus.rsp0_valid !== 1'b1 || bus.rsp_rdata !== 16'h5555) begin
      fails++;
      $display("FAIL ww_rsp: got v%b %h want v1 5555",
               bus.rsp0_valid, bus.rsp_rdata);
    end
    nxt();
  endtask

  task automatic test_reset_mid_read();
    drive0(1, 0, 0, 0);
    settle();
    tests++;
    if (bus.req0_ready !== 1'b1) begin
      fails++;
      $display("FAIL rm_setup: got %b want 1", bus.req0_ready);
    end
    nxt();
    drive0(1, 0, 7, 0);
    rst = 1'b1;
    settle();
    tests++;
    if (bus.req0_ready !== 1'b0 || bus.rsp0_valid !== 1'b1
        || bus.rsp_rdata !== 16'h1000) begin
      fails++;
      $display("FAIL rm_during: got rdy %b v%b %h want 0 v1 1000",
               bus.req0_ready, bus.rsp0_valid, bus.rsp_rdata);
    end
    nxt();
    rst = 1'b0;
    idle();
    settle();
    tests++;
    if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0
        || bus.rsp_rdata !== '0) begin
      fails++;
      $display("FAIL rm_after: got v%b%b %h want v00 0",
               bus.rsp0_valid, bus.rsp1_valid, bus.rsp_rdata);
    end
    nxt();
    drive0(1, 0, 0, 0);
    drive1(1, 0, 7, 0);
    settle();
    tests++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      fails++;
      $display("FAIL rm_tie: got %b%b want 10",
               bus.req0_ready, bus.req1_ready);
    end
    nxt();
    idle();
    settle();
    tests++;
    if (bus.rsp0_valid !== 1'b1 || bus.rsp_rdata !== 16'h1000) begin
      fails++;
      $display("FAIL rm_rsp: got v%b %h want v1 1000",
               bus.rsp0_valid, bus.rsp_rdata);
    end
    nxt();
  endtask

  initial begin
    idle();
    nxt();
    test_reset();
    test_write_read();
    test_round_robin();
    test_cross_hazard();
    test_bypass();
    test_write_write();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
